// File: rtl/fpu_divider_dp_seq_if.sv
// Start/done handshake bundle for the sequential binary64 divider.
// The master issues operands; the slave returns the quotient and flags.
interface fpu_divider_dp_seq_if;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic [63:0] c;
  logic        invalid;
  logic        div_zero;
  logic        overflow;
  logic        underflow;

  modport master (output start, a, b,
                  input  busy, done, c, invalid, div_zero, overflow, underflow);
  modport slave  (input  start, a, b,
                  output busy, done, c, invalid, div_zero, overflow, underflow);
endinterface

// File: rtl/fpu_divider_dp_seq.sv
// Iterative binary64 divider: radix-2 restoring mantissa division, 56 quotient bits,
// round-to-nearest-even, subnormals flushed to zero on input and output.
module fpu_divider_dp_seq (
  input  logic                clk,
  input  logic                rst,
  fpu_divider_dp_seq_if.slave io
);
  typedef enum logic [2:0] {IDLE, CHECK, DIV, ROUND, DONE} state_t;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [62:0] INF  = {11'h7FF, 52'h0};

  state_t             state_q, state_d;
  logic [63:0]        a_q, a_d, b_q, b_d;
  logic [53:0]        rem_q, rem_d;
  logic [52:0]        div_q, div_d;
  logic [55:0]        q_q, q_d;
  logic signed [12:0] e_q, e_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [63:0]        c_q, c_d;
  logic [3:0]         fl_q, fl_d;  // {invalid, div_zero, overflow, underflow}

  // operand classification from the latched operands
  logic [10:0] ea, eb;
  logic [51:0] fa, fb;
  logic        sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign ea     = a_q[62:52];
  assign eb     = b_q[62:52];
  assign fa     = a_q[51:0];
  assign fb     = b_q[51:0];
  assign sgn    = a_q[63] ^ b_q[63];
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  // restoring step
  logic        ge;
  logic [53:0] diff;
  assign ge   = rem_q >= {1'b0, div_q};
  assign diff = ge ? rem_q - {1'b0, div_q} : rem_q;

  // normalise and round
  logic [55:0]        qn;
  logic signed [12:0] en, er;
  logic [52:0]        mant;
  logic               g, st, inc;
  logic [53:0]        m54;
  logic [51:0]        frac;
  always_comb begin
    qn   = q_q[55] ? q_q : {q_q[54:0], 1'b0};
    en   = q_q[55] ? e_q : e_q - 13'sd1;
    mant = qn[55:3];
    g    = qn[2];
    st   = (|qn[1:0]) | (|rem_q);
    inc  = g & (st | mant[0]);
    m54  = {1'b0, mant} + {53'b0, inc};
    // a carry-out means the mantissa became 2.0: renormalise to 1.0
    er   = m54[53] ? en + 13'sd1 : en;
    frac = m54[53] ? 52'b0 : m54[51:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    div_d   = div_q;
    q_d     = q_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    fl_d    = fl_q;
    case (state_q)
      IDLE: if (io.start) begin
        a_d     = io.a;
        b_d     = io.b;
        state_d = CHECK;
      end
      CHECK: begin
        state_d = DONE;
        fl_d    = 4'b0000;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          c_d  = QNAN;
          fl_d = 4'b1000;
        end else if (a_inf) begin
          c_d = {sgn, INF};
        end else if (b_zero) begin
          c_d  = {sgn, INF};
          fl_d = 4'b0100;
        end else if (a_zero || b_inf) begin
          c_d = {sgn, 63'b0};
        end else begin
          fl_d    = fl_q;
          rem_d   = {2'b01, fa};
          div_d   = {1'b1, fb};
          e_d     = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 13'sd1023;
          q_d     = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = {diff[52:0], 1'b0};
        q_d   = {q_q[54:0], ge};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd55) state_d = ROUND;
      end
      ROUND: begin
        state_d = DONE;
        if (er >= 13'sd2047) begin
          c_d  = {sgn, INF};
          fl_d = 4'b0010;
        end else if (er <= 13'sd0) begin
          c_d  = {sgn, 63'b0};
          fl_d = 4'b0001;
        end else begin
          c_d  = {sgn, er[10:0], frac};
          fl_d = 4'b0000;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      e_q     <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      fl_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_q     <= q_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      fl_q    <= fl_d;
    end
  end

  assign io.busy      = (state_q != IDLE);
  assign io.done      = (state_q == DONE);
  assign io.c         = c_q;
  assign io.invalid   = fl_q[3];
  assign io.div_zero  = fl_q[2];
  assign io.overflow  = fl_q[1];
  assign io.underflow = fl_q[0];
endmodule
